reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 8, register and data width; matches the ALU operand width.
REQ-002 Parameter ADDR_W, default 3, register address width; NUM_REGS = 2**ADDR_W = 8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs_addr  input  ADDR_W  read port A address.
REQ-006 rt_addr  input  ADDR_W  read port B address.
REQ-007 rd_addr  input  ADDR_W  write port address.
REQ-008 wr_en  input  1  write enable for the write port.
REQ-009 wr_data  input  DATA_W  write data, driven by the ALU result.
REQ-010 clr  input  1  synchronous clear of all registers.
REQ-011 rs_data  output  DATA_W  combinational read of reg[rs_addr]; drives ALU operand a.
REQ-012 rt_data  output  DATA_W  combinational read of reg[rt_addr]; drives ALU operand b.
REQ-013 zero_flag  output  1  registered; 1 when the last committed write had value 0.
REQ-014 wr_count  output  8  registered count of committed writes, wraps modulo 256.

Function
REQ-015 Reads shall be purely combinational from stored state, with no write-to-read bypass, so that the ALU loop from rs_data/rt_data to wr_data is never combinational.
REQ-016 Register 0 shall always read as 0; writes to address 0 shall be discarded and shall not update zero_flag or wr_count.
REQ-017 On a rising edge with wr_en=1, rd_addr!=0 and clr=0, reg[rd_addr] shall take wr_data, zero_flag shall take (wr_data==0), and wr_count shall increment by 1.
REQ-018 A write shall be visible on rs_data/rt_data from the cycle after the write edge; in the write cycle itself, reads return the old value.
REQ-019 When clr=1 on a rising edge, all registers, zero_flag and wr_count shall go to 0 and any simultaneous wr_en shall be ignored (clr has priority).
REQ-020 When rs_addr==rt_addr, both ports shall return the same value.
REQ-021 wr_count shall wrap from 255 to 0 on the next committed write without side effects.
REQ-022 When wr_en=0, no state shall change.
REQ-023 Unused or unknown addresses shall not exist: all 2**ADDR_W addresses are valid.

Reset
REQ-024 While rst_n=0, all registers shall be 0, zero_flag shall be 0, and wr_count shall be 0, independent of clk.
REQ-025 rs_data and rt_data shall read 0 for every address during reset.
REQ-026 A reset asserted mid-write shall win; the first write after deassertion takes effect on the first rising edge with rst_n=1.

Structure
REQ-027 DATA_W, ADDR_W and NUM_REGS shall live in the shared processor constants package or include, used by reg_file, ALU and the control unit.
REQ-028 The storage array, zero_flag and wr_count shall be in one always block with an asynchronous reset; the read muxes shall be continuous assignments.
REQ-029 No sub-module is required; the register array is inline.

Verification
REQ-030 Reset -> all 8 addresses read 0 on both ports, zero_flag=0, wr_count=0.
REQ-031 Write 0xA5 to r3, then read rs_addr=3 and rt_addr=3 -> both 0xA5 on the next cycle, and 0x00 (old value) in the write cycle; wr_count=1.
REQ-032 Write 0x7F to r0 -> r0 still reads 0x00; zero_flag and wr_count unchanged.
REQ-033 Write 0x00 to r5 after a nonzero write -> zero_flag=1; then write 0x01 to r6 -> zero_flag=0.
REQ-034 clr=1 together with wr_en=1, rd_addr=2, wr_data=0x33 -> all registers 0, r2 reads 0x00, wr_count=0.
REQ-035 256 consecutive writes of 0x11 to r1 -> wr_count reads 0 and r1 reads 0x11; rst_n pulsed low between edges -> everything 0 immediately.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared processor constants for the register file, ALU and control unit,
// plus small helpers used by the register file write path.
package reg_file_pkg;

    // Datapath width shared by registers and ALU operands.
    localparam int DATA_W   = 8;
    // Register address width; every encoding is a real register.
    localparam int ADDR_W   = 3;
    // Number of architectural registers.
    localparam int NUM_REGS = 2 ** ADDR_W;
    // Width of the committed-write counter.
    localparam int CNT_W    = 8;

    // A write commits only when enabled, not overridden by clear, and not
    // aimed at the hard-wired zero register.
    function automatic logic write_commits(input logic wr_en,
                                           input logic clr,
                                           input logic addr_nonzero);
        return wr_en & ~clr & addr_nonzero;
    endfunction

    // Next counter value; wraps naturally at the counter width.
    function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] cnt);
        return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 hard-wired to zero, a synchronous clear, a zero flag tracking
// the last committed write, and a wrapping count of committed writes.
module reg_file #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              zero_flag,
    output logic [7:0]        wr_count
);

    import reg_file_pkg::*;

    localparam int NUM_REGS = 2 ** ADDR_W;

    // Architectural state and its next-state values.
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              zero_q;
    logic              zero_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Decoded write-path controls.
    logic              addr_nonzero_s;
    logic              commit_s;
    logic              data_zero_s;

    assign addr_nonzero_s = (rd_addr != {ADDR_W{1'b0}});
    assign commit_s       = write_commits(wr_en, clr, addr_nonzero_s);
    assign data_zero_s    = (wr_data == {DATA_W{1'b0}});

    // Next-state logic: clear dominates, then a committed write, else hold.
    always_comb begin
        regs_d = regs_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = {DATA_W{1'b0}};
            end
            zero_d = 1'b0;
            cnt_d  = {CNT_W{1'b0}};
        end else if (commit_s) begin
            regs_d[rd_addr] = wr_data;
            zero_d          = data_zero_s;
            cnt_d           = count_inc(cnt_q);
        end else begin
            zero_d = zero_q;
            cnt_d  = cnt_q;
        end
        // Register 0 never holds anything but zero.
        regs_d[0] = {DATA_W{1'b0}};
    end

    // All state in one block with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            zero_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

    // Reads come straight from stored state: no bypass, so the ALU loop
    // through wr_data always passes through a register.
    assign rs_data = (rs_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_q[rs_addr];
    assign rt_data = (rt_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_q[rt_addr];

    assign zero_flag = zero_q;
    assign wr_count  = cnt_q;

endmodule
